// File: rtl/psram_responder.sv
// psram_responder: memory end of a synchronous CellularRAM-style PSRAM bus.
// Accepts BCR configuration writes and latency-delayed burst reads/writes,
// strobing psram_wait once per data beat, backed by an internal 16-bit array.
module psram_responder #(
  parameter int          adr_width     = 22,
  parameter int          mem_adr_width = 10,
  parameter logic [15:0] bcr_default   = 16'h9D1F
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 psram_clk_en,
  input  logic [adr_width-1:0] psram_adr,
  input  logic [15:0]          psram_dq_i,
  output logic [15:0]          psram_dq_o,
  output logic                 psram_dq_oe,
  input  logic                 psram_ce_n,
  input  logic                 psram_we_n,
  input  logic                 psram_oe_n,
  input  logic                 psram_adv_n,
  input  logic                 psram_cre,
  input  logic                 psram_lb,
  input  logic                 psram_ub,
  output logic                 psram_wait
);

  localparam int depth = 1 << mem_adr_width;

  typedef enum logic [2:0] {IDLE, CFG_ACK, LATENCY, BURST, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [15:0]              bcr_q, bcr_d;
  logic [mem_adr_width-1:0] badr_q, badr_d;
  logic [mem_adr_width-1:0] badr_inc, badr_nxt, wrap_mask;
  logic                     is_wr_q, is_wr_d;
  logic [2:0]               lat_q, lat_d;
  logic [4:0]               cnt_q, cnt_d, last_beat;
  logic                     burst_fixed;
  logic                     wait_q, wait_d;
  logic                     dq_oe_q, dq_oe_d;
  logic [15:0]              dq_o_q, dq_o_d;
  logic                     wr_beat;
  logic [15:0]              mem [depth];

  // High address bits alias onto the array; they are intentionally ignored.
  logic unused_adr;
  assign unused_adr = ^psram_adr[adr_width-1:mem_adr_width];

  // Decode burst length from bcr[2:0] and compute the next beat address (wrapping or linear).
  always_comb begin
    burst_fixed = 1'b1;
    last_beat   = 5'd0;
    case (bcr_q[2:0])
      3'b001:  last_beat = 5'd3;
      3'b010:  last_beat = 5'd7;
      3'b011:  last_beat = 5'd15;
      3'b100:  last_beat = 5'd31;
      default: burst_fixed = 1'b0;
    endcase
    wrap_mask = mem_adr_width'(last_beat);
    badr_inc  = badr_q + mem_adr_width'(1);
    if (burst_fixed && !bcr_q[3]) begin
      badr_nxt = (badr_q & ~wrap_mask) | (badr_inc & wrap_mask);
    end else begin
      badr_nxt = badr_inc;
    end
  end

  // Next-state and next-register logic; ce_n high aborts from any state.
  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bcr_d    = bcr_q;
    badr_d   = badr_q;
    is_wr_d  = is_wr_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    dq_oe_d  = dq_oe_q;
    dq_o_d   = dq_o_q;
    wr_beat  = 1'b0;
    if (psram_ce_n) begin
      state_d = IDLE;
      wait_d  = 1'b0;
      dq_oe_d = 1'b0;
    end else if (psram_clk_en) begin
      wait_d  = 1'b0;
      dq_oe_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!psram_adv_n) begin
            if (psram_cre) begin
              if (!psram_we_n) begin
                bcr_d   = psram_dq_i;
                wait_d  = 1'b1;
                state_d = CFG_ACK;
              end else begin
                state_d = HOLD;
              end
            end else begin
              badr_d  = psram_adr[mem_adr_width-1:0];
              is_wr_d = ~psram_we_n;
              lat_d   = bcr_q[13:11];
              cnt_d   = 5'd0;
              state_d = LATENCY;
            end
          end
        end
        CFG_ACK: state_d = HOLD;
        LATENCY: begin
          // Code 0 behaves like 1: the countdown always spends at least one cycle here.
          if (lat_q != 3'd0) lat_d = lat_q - 3'd1;
          if (lat_q <= 3'd1) state_d = BURST;
        end
        BURST: begin
          wait_d = 1'b1;
          if (is_wr_q) begin
            wr_beat = 1'b1;
          end else begin
            dq_o_d  = mem[badr_q];
            dq_oe_d = ~psram_oe_n;
          end
          badr_d = badr_nxt;
          cnt_d  = cnt_q + 5'd1;
          if (burst_fixed && cnt_q == last_beat) state_d = HOLD;
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers: configuration, burst address, latency/beat counters and bus outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bcr_q   <= bcr_default;
      badr_q  <= '0;
      is_wr_q <= 1'b0;
      lat_q   <= 3'd0;
      cnt_q   <= 5'd0;
      wait_q  <= 1'b0;
      dq_oe_q <= 1'b0;
      dq_o_q  <= 16'h0000;
    end else begin
      bcr_q   <= bcr_d;
      badr_q  <= badr_d;
      is_wr_q <= is_wr_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      dq_oe_q <= dq_oe_d;
      dq_o_q  <= dq_o_d;
    end
  end

  // Byte-lane writes into the backing array on write beats.
  // NOTE: the array has no reset; its contents survive sys_rst, which also lets it map onto RAM primitives.
  always_ff @(posedge sys_clk) begin
    if (wr_beat && !sys_rst) begin
      if (psram_lb) mem[badr_q][7:0]  <= psram_dq_i[7:0];
      if (psram_ub) mem[badr_q][15:8] <= psram_dq_i[15:8];
    end
  end

  assign psram_wait  = wait_q;
  assign psram_dq_oe = dq_oe_q;
  assign psram_dq_o  = dq_o_q;

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: randomized bench for psram_responder with a transaction-level
// reference model (beat index arithmetic) checked against the DUT every cycle.
module tb_psram_responder;

  localparam int          ADR_W  = 22;
  localparam int          MEM_W  = 10;
  localparam int          DEPTH  = 1 << MEM_W;
  localparam logic [15:0] BCR_DEF = 16'h9D1F;
  localparam int          BUDGET = 4000;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             psram_clk_en;
  logic [ADR_W-1:0] psram_adr;
  logic [15:0]      psram_dq_i;
  logic [15:0]      psram_dq_o;
  logic             psram_dq_oe;
  logic             psram_ce_n;
  logic             psram_we_n;
  logic             psram_oe_n;
  logic             psram_adv_n;
  logic             psram_cre;
  logic             psram_lb;
  logic             psram_ub;
  logic             psram_wait;

  psram_responder #(
    .adr_width    (ADR_W),
    .mem_adr_width(MEM_W),
    .bcr_default  (BCR_DEF)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .psram_clk_en(psram_clk_en),
    .psram_adr   (psram_adr),
    .psram_dq_i  (psram_dq_i),
    .psram_dq_o  (psram_dq_o),
    .psram_dq_oe (psram_dq_oe),
    .psram_ce_n  (psram_ce_n),
    .psram_we_n  (psram_we_n),
    .psram_oe_n  (psram_oe_n),
    .psram_adv_n (psram_adv_n),
    .psram_cre   (psram_cre),
    .psram_lb    (psram_lb),
    .psram_ub    (psram_ub),
    .psram_wait  (psram_wait)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act !== want) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 = ready for an address cycle, 1 = waiting for ce_n high, 2 = access in flight.
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] m_bcr;
  int          m_mode, m_k, m_first, m_base, m_len;
  bit          m_wr, m_nowrap;
  logic        exp_wait = 1'b0, exp_oe = 1'b0;
  logic [15:0] exp_dq   = 16'h0000;

  // Address of beat n: linear mod depth, or wrapped inside the aligned burst block.
  function automatic int beat_addr(input int n);
    if (m_len == 0 || m_nowrap) return (m_base + n) % DEPTH;
    return (m_base / m_len) * m_len + (m_base + n) % m_len;
  endfunction

  // Model: beat n lands on enabled edge number max(lat,1)+1+n after the address edge.
  always @(posedge sys_clk) begin : model
    int n, a, lat, code;
    if (sys_rst) begin
      m_mode = 0; m_bcr = BCR_DEF;
      exp_wait = 1'b0; exp_oe = 1'b0; exp_dq = 16'h0000;
    end else if (psram_ce_n) begin
      m_mode = 0; exp_wait = 1'b0; exp_oe = 1'b0;
    end else if (psram_clk_en) begin
      exp_wait = 1'b0; exp_oe = 1'b0;
      if (m_mode == 0) begin
        if (!psram_adv_n) begin
          if (psram_cre) begin
            m_mode = 1;
            if (!psram_we_n) begin
              m_bcr = psram_dq_i; exp_wait = 1'b1;
            end
          end else begin
            m_mode   = 2;
            m_k      = 0;
            m_base   = int'(psram_adr) % DEPTH;
            m_wr     = !psram_we_n;
            lat      = int'(m_bcr[13:11]);
            m_first  = (lat < 1 ? 1 : lat) + 1;
            code     = int'(m_bcr[2:0]);
            m_len    = (code >= 1 && code <= 4) ? (1 << (code + 1)) : 0;
            m_nowrap = m_bcr[3];
          end
        end
      end else if (m_mode == 2) begin
        m_k++;
        if (m_k >= m_first) begin
          n = m_k - m_first;
          a = beat_addr(n);
          exp_wait = 1'b1;
          if (m_wr) begin
            if (psram_lb) ref_mem[a][7:0]  = psram_dq_i[7:0];
            if (psram_ub) ref_mem[a][15:8] = psram_dq_i[15:8];
          end else begin
            exp_dq = ref_mem[a];
            exp_oe = !psram_oe_n;
          end
          if (m_len != 0 && n == m_len - 1) m_mode = 1;
        end
      end
    end
  end

  // Compare DUT outputs to the model on every cycle, away from the active edge.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("cyc_wait",  16'(psram_wait),  16'(exp_wait));
      check("cyc_dq_oe", 16'(psram_dq_oe), 16'(exp_oe));
      check("cyc_dq_o",  psram_dq_o,       exp_dq);
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] wbuf [DEPTH];
  logic [15:0] obs [$];
  int          lat_obs;

  // Present write data for the beat that the next enabled edge would perform.
  task automatic drive_wdata();
    if (m_mode == 2 && m_wr && m_k + 1 >= m_first)
      psram_dq_i = wbuf[(m_k + 1 - m_first) % DEPTH];
    else
      psram_dq_i = 16'($urandom);
  endtask

  task automatic cfg_write(input logic [15:0] val);
    @(negedge sys_clk);
    psram_clk_en = 1'b1; psram_ce_n = 1'b0; psram_adv_n = 1'b0;
    psram_cre = 1'b1; psram_we_n = 1'b0; psram_dq_i = val;
    psram_adr = ADR_W'($urandom);
    @(negedge sys_clk);
    psram_adv_n = 1'b1; psram_cre = 1'b0;
    check("cfg_ack_high", 16'(psram_wait), 16'h1);
    @(negedge sys_clk);
    check("cfg_ack_one_cycle", 16'(psram_wait), 16'h0);
    psram_ce_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // One burst: address cycle, run until nbeats beats (or a fixed burst ends), tail cycles, then abort.
  task automatic access(input logic [MEM_W-1:0] base, input bit wr, input int nbeats,
                        input bit oe_n_v, input bit lb_v, input bit ub_v, input int en_pct,
                        input int stall_from, input int tail, input bit rst_end);
    int left;
    bit en;
    obs.delete();
    lat_obs = -1;
    left    = -1;
    @(negedge sys_clk);
    psram_clk_en = 1'b1; psram_ce_n = 1'b0; psram_adv_n = 1'b0; psram_cre = 1'b0;
    psram_we_n = !wr; psram_oe_n = oe_n_v; psram_lb = lb_v; psram_ub = ub_v;
    psram_adr = {12'($urandom), base};
    for (int j = 1; j <= BUDGET; j++) begin
      @(negedge sys_clk);
      if (psram_wait && psram_clk_en) begin
        obs.push_back(psram_dq_o);
        if (lat_obs < 0) lat_obs = j - 1;
      end
      if (left < 0 && (m_mode != 2 || (m_k >= m_first && m_k - m_first + 1 >= nbeats)))
        left = tail;
      if (left == 0) break;
      if (left > 0) left--;
      // Address strobes outside IDLE must be ignored; sprinkle some in.
      psram_adv_n = ($urandom_range(0, 9) != 0);
      psram_cre   = 1'($urandom);
      psram_adr   = ADR_W'($urandom);
      en = (stall_from != 0 && j >= stall_from && j < stall_from + 3) ? 1'b0
           : ($urandom_range(1, 100) <= en_pct);
      psram_clk_en = en;
      drive_wdata();
    end
    check("access_completed", 16'(left == 0), 16'h1);
    psram_adv_n = 1'b1; psram_cre = 1'b0;
    if (rst_end) begin
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0; psram_ce_n = 1'b1; psram_clk_en = 1'b1;
    end else begin
      psram_ce_n = 1'b1;
      @(negedge sys_clk);
      psram_clk_en = 1'b1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t3 [4];
    logic [15:0] t4 [4];
    sys_rst = 1'b1; psram_clk_en = 1'b1; psram_ce_n = 1'b1; psram_we_n = 1'b1;
    psram_oe_n = 1'b1; psram_adv_n = 1'b1; psram_cre = 1'b0; psram_lb = 1'b1;
    psram_ub = 1'b1; psram_dq_i = 16'h0000; psram_adr = '0;
    repeat (2) @(posedge sys_clk);
    chk_en = 1'b1;
    @(negedge sys_clk);
    check("rst_wait",  16'(psram_wait),  16'h0);
    check("rst_dq_oe", 16'(psram_dq_oe), 16'h0);
    check("rst_dq_o",  psram_dq_o,       16'h0000);
    sys_rst = 1'b0;

    // Preload every word through a continuous default-BCR burst that rolls over the top.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 16'($urandom);
    access(10'h3F8, 1'b1, DEPTH, 1'b1, 1'b1, 1'b1, 75, 0, 0, 1'b0);

    // BCR write: latency 3, continuous, no wrap.
    cfg_write(16'h1D1F);

    // Four-beat write to 0x010; first beat four cycles after the address cycle.
    wbuf[0] = 16'hAAAA; wbuf[1] = 16'h5555; wbuf[2] = 16'h1234; wbuf[3] = 16'hBEEF;
    access(10'h010, 1'b1, 4, 1'b1, 1'b1, 1'b1, 100, 0, 0, 1'b0);
    check("t2_first_wait_latency", 16'(lat_obs), 16'd4);

    // Read it back.
    t3 = '{16'hAAAA, 16'h5555, 16'h1234, 16'hBEEF};
    access(10'h010, 1'b0, 4, 1'b0, 1'b1, 1'b1, 100, 0, 0, 1'b0);
    check("t3_beat_count", 16'(obs.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      check("t3_read_beat", (i < obs.size()) ? obs[i] : 16'hxxxx, t3[i]);

    // Wrapping 4-beat burst from 0x012, then ce_n held low: no further beats.
    cfg_write(16'h1D11);
    t4 = '{16'h1234, 16'hBEEF, 16'hAAAA, 16'h5555};
    access(10'h012, 1'b0, 32, 1'b0, 1'b1, 1'b1, 100, 0, 5, 1'b0);
    check("t4_beat_count", 16'(obs.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      check("t4_wrap_beat", (i < obs.size()) ? obs[i] : 16'hxxxx, t4[i]);

    // Byte lanes: full write 0xFFFF, then low lane only with 0x0000.
    wbuf[0] = 16'hFFFF;
    access(10'h020, 1'b1, 1, 1'b1, 1'b1, 1'b1, 100, 0, 0, 1'b0);
    wbuf[0] = 16'h0000;
    access(10'h020, 1'b1, 1, 1'b1, 1'b1, 1'b0, 100, 0, 0, 1'b0);
    access(10'h020, 1'b0, 1, 1'b0, 1'b1, 1'b1, 100, 0, 0, 1'b0);
    check("t5_lane_merge", (obs.size() > 0) ? obs[0] : 16'hxxxx, 16'hFF00);

    // Clock-enable stall in latency, ce_n abort mid-burst, then reset mid-burst.
    cfg_write(16'h1D1F);
    access(10'h010, 1'b0, 3, 1'b0, 1'b1, 1'b1, 100, 2, 0, 1'b0);
    check("t6_stretched_latency", 16'(lat_obs), 16'd7);
    check("t6_abort_wait",  16'(psram_wait),  16'h0);
    check("t6_abort_dq_oe", 16'(psram_dq_oe), 16'h0);
    access(10'h011, 1'b0, 2, 1'b0, 1'b1, 1'b1, 100, 0, 0, 1'b1);
    check("t6_rst_wait",  16'(psram_wait),  16'h0);
    check("t6_rst_dq_oe", 16'(psram_dq_oe), 16'h0);
    check("t6_rst_dq_o",  psram_dq_o,       16'h0000);

    // Randomized traffic: BCR changes, reads/writes, lanes, clock gating, aborts and resets.
    for (int it = 0; it < 60; it++) begin
      bit wr;
      if ($urandom_range(0, 9) < 3)
        cfg_write({2'($urandom), 3'($urandom), 7'($urandom), 1'($urandom), 3'($urandom)});
      wr = 1'($urandom);
      for (int i = 0; i < 64; i++) wbuf[i] = 16'($urandom);
      access(MEM_W'($urandom), wr, int'($urandom_range(1, 40)), 1'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(60, 100)), 0,
             int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
